// File: rtl/echo_ranger_ctrl.sv
// Ultrasonic echo ranger controller: fires a trigger pulse, times the
// returned echo in DIV-cycle units, and enforces a dead time between shots.
module echo_ranger_ctrl #(
  parameter int TRIG_CYC    = 1000,
  parameter int DIV         = 100,
  parameter int RISE_TO     = 3000000,
  parameter int HOLDOFF_CYC = 6000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        auto,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] echo_t,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  // Terminal counts for the shared cycle counter in each timed state.
  localparam logic [31:0] L_TRIG_LAST = 32'(TRIG_CYC - 1);
  localparam logic [31:0] L_DIV_LAST  = 32'(DIV - 1);
  localparam logic [31:0] L_RISE_LAST = 32'(RISE_TO - 1);
  localparam logic [31:0] L_HOLD_LAST = 32'(HOLDOFF_CYC - 1);

  logic [2:0]  r_state;
  logic [31:0] r_cnt;       // state timer; doubles as the prescaler in MEASURE
  logic [15:0] r_width;
  logic [15:0] r_echo_t;
  logic        r_valid;
  logic        r_timeout;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_echo_d;

  logic        w_rise;
  logic        w_fall;
  logic        w_pre_wrap;
  logic [15:0] w_width_inc;

  // Edges come only from the synchronized echo and its one-cycle delay.
  assign w_rise      = r_sync2 & ~r_echo_d;
  assign w_fall      = ~r_sync2 & r_echo_d;
  assign w_pre_wrap  = (r_cnt == L_DIV_LAST);
  // Width including the current MEASURE cycle, so the cycle on which the
  // falling edge is seen still counts toward the result.
  assign w_width_inc = r_width + {15'd0, w_pre_wrap};

  assign trig    = (r_state == S_TRIG);
  assign busy    = (r_state != S_IDLE);
  assign echo_t  = r_echo_t;
  assign valid   = r_valid;
  assign timeout = r_timeout;

  // Two-flop synchronizer for the asynchronous echo, plus an edge-detect tap.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous
      // stage's old value; blocking here would collapse the chain to one flop.
      r_sync1  <= echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
    end
  end

  // Measurement sequencer: trigger, wait for echo, time it, then hold off.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_width   <= '0;
      r_echo_t  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start || auto) begin
            r_state <= S_TRIG;
            r_cnt   <= '0;
          end
        end
        S_TRIG: begin
          if (r_cnt == L_TRIG_LAST) begin
            r_state <= S_WAIT_RISE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WAIT_RISE: begin
          if (w_rise) begin
            r_state <= S_MEASURE;
            r_cnt   <= '0;
            r_width <= '0;
          end else if (r_cnt == L_RISE_LAST) begin
            r_state   <= S_HOLDOFF;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_MEASURE: begin
          if (w_width_inc == 16'hFFFF) begin
            r_state   <= S_HOLDOFF;
            r_cnt     <= '0;
            r_echo_t  <= 16'hFFFF;
            r_timeout <= 1'b1;
          end else if (w_fall) begin
            r_state  <= S_HOLDOFF;
            r_cnt    <= '0;
            r_echo_t <= w_width_inc;
            r_valid  <= 1'b1;
          end else begin
            r_width <= w_width_inc;
            r_cnt   <= w_pre_wrap ? 32'd0 : r_cnt + 32'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == L_HOLD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
